// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_pkg
// Purpose  : Shared state encoding and default widths for the register-file
//            dumper (reg_file_dumper and its helpers).
// Revision : 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

    // Default data width (matches register file) and address width
    localparam int c_default_n    = 32;
    localparam int c_default_addr = 5;

    // Fixed state encoding, shared with anything decoding the FSM
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_read  = 3'd1;
    localparam logic [2:0] c_st_send  = 3'd2;
    localparam logic [2:0] c_st_final = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_st_idle,
        ST_READ  = c_st_read,
        ST_SEND  = c_st_send,
        ST_FINAL = c_st_final,
        ST_DONE  = c_st_done
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_if
// Purpose  : Control, register-file read port and valid/ready dump stream of
//            the register-file dumper. master = dumper side, slave = host.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_dump_if #(
    parameter int N    = reg_dump_pkg::c_default_n,
    parameter int ADDR = reg_dump_pkg::c_default_addr
);
    logic            start;
    logic [ADDR-1:0] first_addr;
    logic [ADDR-1:0] last_addr;
    logic [ADDR-1:0] rd_addr;
    logic [N-1:0]    rd_data;
    logic            dump_valid;
    logic            dump_ready;
    logic [N-1:0]    dump_data;
    logic [ADDR-1:0] dump_addr;
    logic            dump_last;
    logic            busy;
    logic            done;

    modport master (
        input  start, first_addr, last_addr, rd_data, dump_ready,
        output rd_addr, dump_valid, dump_data, dump_addr, dump_last, busy, done
    );

    modport slave (
        output start, first_addr, last_addr, rd_data, dump_ready,
        input  rd_addr, dump_valid, dump_data, dump_addr, dump_last, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/reg_dump_checksum.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_checksum
// Purpose  : N-bit XOR accumulator with synchronous clear and enable; folds
//            every dumped word into a running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_checksum #(
    parameter int N = reg_dump_pkg::c_default_n
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clr,
    input  wire logic         en,
    input  wire logic [N-1:0] din,
    output      logic [N-1:0] sum
);

    logic [N-1:0] r_sum;

    // Accumulate: clear wins over enable so a new dump starts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (clr) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= r_sum ^ din;
        end
    end

    assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/reg_file_dumper.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_dumper
// Purpose  : Walks a programmed register-file address range (with wrap),
//            snapshots each word through one read port and streams it out
//            over valid/ready with address and last tags.
//            Build option REG_DUMP_CHECKSUM_EN: append one XOR-checksum word
//            after the last register word and move the last tag onto it.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_dumper
    import reg_dump_pkg::*;
#(
    parameter int N    = c_default_n,
    parameter int ADDR = c_default_addr
) (
    input wire logic  clk,
    input wire logic  reset,
    reg_dump_if.master bus
);

    state_t          r_state;
    state_t          w_next;
    logic [ADDR-1:0] r_cnt;
    logic [ADDR-1:0] r_last;
    logic [N-1:0]    r_data;
    logic            w_at_last;

    assign w_at_last = (r_cnt == r_last);

`ifdef REG_DUMP_CHECKSUM_EN
    logic [N-1:0] w_sum;

    // Checksum restarts on start accept and folds each word as it is captured
    reg_dump_checksum #(.N(N)) u_checksum (
        .clk   (clk),
        .reset (reset),
        .clr   ((r_state == ST_IDLE) && bus.start),
        .en    (r_state == ST_READ),
        .din   (bus.rd_data),
        .sum   (w_sum)
    );
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_READ;
            ST_READ:  w_next = ST_SEND;
            ST_SEND: begin
                if (bus.dump_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    w_next = w_at_last ? ST_FINAL : ST_READ;
`else
                    w_next = w_at_last ? ST_DONE : ST_READ;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_FINAL: if (bus.dump_ready) w_next = ST_DONE;
`endif
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Address counter, latched end address and captured word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_last <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_cnt  <= bus.first_addr;
                        r_last <= bus.last_addr;
                    end
                end
                ST_READ: r_data <= bus.rd_data;
                ST_SEND: begin
                    // Natural overflow gives the modulo-2**ADDR wrap
                    if (bus.dump_ready && !w_at_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so reset clears them without waiting a clock
    always_comb begin
        bus.rd_addr    = r_cnt;
        bus.dump_valid = 1'b0;
        bus.dump_data  = r_data;
        bus.dump_addr  = r_cnt;
        bus.dump_last  = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            ST_READ: bus.busy = 1'b1;
            ST_SEND: begin
                bus.busy       = 1'b1;
                bus.dump_valid = 1'b1;
`ifndef REG_DUMP_CHECKSUM_EN
                bus.dump_last  = w_at_last;
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_FINAL: begin
                bus.busy       = 1'b1;
                bus.dump_valid = 1'b1;
                bus.dump_data  = w_sum;
                bus.dump_addr  = r_last;
                bus.dump_last  = 1'b1;
            end
`endif
            ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_dumper
// Purpose  : Self-checking bench for reg_file_dumper: directed dumps pushed to
//            a scoreboard queue, checked by an independent stream monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_dumper;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  a;
        logic        l;
    } word_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_dump_if #(.N(32), .ADDR(5)) bus ();

    logic [31:0] rf [32];
    assign bus.rd_data = rf[bus.rd_addr];

    reg_file_dumper #(.N(32), .ADDR(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    checks   = 0;
    int    errors   = 0;
    int    busy_cnt = 0;
    int    done_cnt = 0;
    word_t sb [$];
    word_t held;
    bit    holding  = 1'b0;

    // Stream monitor: stability under backpressure and in-order scoreboard
    always @(negedge clk) begin
        word_t got;
        word_t exp;
        if (reset) begin
            holding = 1'b0;
        end else begin
            got = {bus.dump_data, bus.dump_addr, bus.dump_last};
            if (holding) begin
                checks++;
                if (!bus.dump_valid || got != held) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b d=%h a=%0d l=%0b, required valid=1 d=%h a=%0d l=%0b",
                             bus.dump_valid, got.d, got.a, got.l, held.d, held.a, held.l);
                end
            end
            if (bus.dump_valid && bus.dump_ready) begin
                holding = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: d=%h a=%0d l=%0b, required no word", got.d, got.a, got.l);
                end else begin
                    exp = sb.pop_front();
                    if (got != exp) begin
                        errors++;
                        $display("FAIL word: d=%h a=%0d l=%0b, required d=%h a=%0d l=%0b",
                                 got.d, got.a, got.l, exp.d, exp.a, exp.l);
                    end
                end
            end else if (bus.dump_valid) begin
                holding = 1'b1;
                held    = got;
            end else begin
                holding = 1'b0;
            end
            if (bus.done) begin
                checks++;
                if (bus.busy || bus.dump_valid) begin
                    errors++;
                    $display("FAIL done_alone: busy=%0b valid=%0b, required 0 0", bus.busy, bus.dump_valid);
                end
            end
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        busy_cnt = 0;
        done_cnt = 0;
        tick();
        bus.start      = 1'b1;
        bus.first_addr = f;
        bus.last_addr  = l;
        tick();
        bus.start      = 1'b0;
    endtask

    // Expected words for a range using the preloaded register-file image
    task automatic expect_range(input logic [4:0] f, input logic [4:0] l);
        logic [4:0]  a;
        logic [31:0] x;
        a = f;
        x = '0;
        for (int i = 0; i < 32; i++) begin
            sb.push_back({rf[a], a, (a == l) && (CK == 0)});
            x = x ^ rf[a];
            if (a == l) break;
            a = a + 5'd1;
        end
        if (CK != 0) sb.push_back({x, l, 1'b1});
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        #1;
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_addr(input string name, input logic [4:0] a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.dump_valid && bus.dump_addr == a) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_reach_word"}, 64'(seen), 64'd1);
    endtask

    function automatic logic [63:0] all_outs();
        return {20'd0, bus.dump_valid, bus.busy, bus.done, bus.dump_last,
                bus.dump_data, bus.dump_addr, bus.rd_addr};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        bus.dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 32'h11);

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;

        // Basic range 2..4 with hand-computed words
        sb.push_back({32'h22, 5'd2, 1'b0});
        sb.push_back({32'h33, 5'd3, 1'b0});
        sb.push_back({32'h44, 5'd4, CK == 0});
        if (CK != 0) sb.push_back({32'h55, 5'd4, 1'b1});
        start_dump(5'd2, 5'd4);
        chk("accept_state", {57'd0, bus.busy, bus.dump_valid, bus.rd_addr}, {57'd0, 1'b1, 1'b0, 5'd2});
        tick();
        chk("first_valid", 64'(bus.dump_valid), 64'd1);
        wait_done("basic", 6 + CK);

        // Wrap 30,31,0,1
        expect_range(5'd30, 5'd1);
        start_dump(5'd30, 5'd1);
        wait_done("wrap", 8 + CK);

        // Full range
        expect_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        wait_done("full", 64 + CK);

        // Backpressure with an ignored start pulse mid-dump
        expect_range(5'd5, 5'd7);
        bus.dump_ready = 1'b0;
        start_dump(5'd5, 5'd7);
        wait_addr("bp", 5'd5);
        repeat (2) tick();
        bus.start      = 1'b1;
        bus.first_addr = 5'd10;
        bus.last_addr  = 5'd12;
        tick();
        bus.start      = 1'b0;
        repeat (2) tick();
        bus.dump_ready = 1'b1;
        wait_done("backpressure", 11 + CK);

        // Snapshot: write after capture is not reflected
        expect_range(5'd2, 5'd4);
        start_dump(5'd2, 5'd4);
        wait_addr("snap", 5'd3);
        rf[3] = 32'hDEAD;
        wait_done("snapshot", 6 + CK);
        rf[3] = 32'h33;

        // Reset during the second word, then a clean dump
        expect_range(5'd2, 5'd4);
        start_dump(5'd2, 5'd4);
        wait_addr("rst", 5'd3);
        reset = 1'b1;
        #1;
        chk("reset_async", all_outs(), 64'd0);
        sb.delete();
        repeat (4) tick();
        chk("reset_no_done", 64'(done_cnt), 64'd0);
        reset = 1'b0;
        tick();
        expect_range(5'd10, 5'd13);
        start_dump(5'd10, 5'd13);
        wait_done("after_reset", 8 + CK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_dumper.md
# reg_file_dumper

Sequential read-out engine for the register file: on a start pulse it walks a programmed address range through one register-file read port, snapshots each word, and streams it out over a valid/ready interface with address and last tags. It sits beside the register file as its debug/context-save reader, sharing a read port with the datapath when the core is halted.

## Interface
- N, 32, data width, equal to the register file width
- ADDR, 5, address width; the register file holds 2**ADDR entries
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- Start_i  in  1  one-cycle request to begin a dump; sampled only in IDLE
- First_Addr_i  in  ADDR  first register to dump; latched with Start_i
- Last_Addr_i  in  ADDR  last register to dump; latched with Start_i
- Rd_Addr_o  out  ADDR  read address driven to the register-file read port
- Rd_Data_i  in  N  combinational read data returned for Rd_Addr_o
- Dump_Valid_o  out  1  output word valid
- Dump_Ready_i  in  1  consumer accepts word when high with Dump_Valid_o
- Dump_Data_o  out  N  captured register value, or checksum word
- Dump_Addr_o  out  ADDR  register index of Dump_Data_o
- Dump_Last_o  out  1  marks the final word of the dump
- Busy_o  out  1  high from the cycle after Start_i accept until Done_o
- Done_o  out  1  one-cycle pulse at end of dump

## Operation
- States: IDLE, READ, SEND, FINAL, DONE.
- IDLE: Start_i=1 latches First/Last, loads the address counter with First, clears the checksum, and moves to READ. Start_i in any other state is ignored.
- READ: Rd_Addr_o = address counter; captures Rd_Data_i into the data register, folds it into the checksum, and moves to SEND.
- SEND: Dump_Valid_o=1; data, address, and last are held stable until handshake. On Valid&Ready: if counter==Last, go to FINAL (macro defined) or DONE; otherwise increment the counter modulo 2**ADDR and return to READ.
- FINAL: Dump_Valid_o=1, Dump_Data_o=checksum, Dump_Addr_o=Last, Dump_Last_o=1. On handshake, go to DONE.
- DONE: Done_o=1 for one cycle, then IDLE.
- Wrap: Last < First walks through 2**ADDR-1 to 0 and on to Last. First==Last dumps exactly one word. First=Last+1 (mod 2**ADDR) dumps all 2**ADDR entries.
- Snapshot: each word is the value read in its READ cycle. Register-file writes after capture are not reflected in the word.
- Rd_Addr_o shows the counter in all states. Its value outside READ is don't-care for the register file.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, checksum 0.
- Start_i accepted at edge k: Busy_o=1 and state READ from k. First Dump_Valid_o at k+1.
- Cost per word: one READ cycle plus SEND cycles until Ready. Peak rate is one word per 2 cycles.
- Dump_Valid_o never drops without a handshake, except on reset.
- Dump_Last_o is high only on the final word. That is the last register word without the macro, or the checksum word with it.
- Done_o is high for the cycle after the final handshake. Busy_o falls in the same cycle. A new Start_i is accepted in the following IDLE cycle.
- Reset asserted mid-dump: Valid, Busy, and Done go low asynchronously. No partial Done_o. The dump is abandoned.

## Configuration
- REG_DUMP_CHECKSUM_EN defined: after the last register word, one extra word carries the XOR of all dumped data words, and Dump_Last_o moves to that word.
- Undefined: the FINAL state and checksum register are not built, and SEND goes directly to DONE.

## Structure
- Shared package/header reg_dump_pkg holds the state encoding localparams (IDLE=0, READ=1, SEND=2, FINAL=3, DONE=4) and the default N/ADDR values.
- One sub-module, reg_dump_checksum: N-bit XOR accumulator with clear and enable. It is instantiated only under REG_DUMP_CHECKSUM_EN.

## Test plan
- Preload RF[i]=i*0x11. Start with First=2, Last=4, Ready=1: words (2,0x22), (3,0x33), (4,0x44). Last on the 4 word, or on checksum 0x55 with the macro. Done_o one pulse. Busy_o high for 6 cycles without the macro, 7 with it.
- Wrap: First=30, Last=1 gives addresses 30, 31, 0, 1 in order, 4 words.
- Full range: First=0, Last=31 gives 32 words. The checksum equals the XOR of all 32 preloaded values.
- Backpressure: Ready held low 5 cycles in SEND. Data, Addr, and Last stay stable, and no word is skipped or duplicated. A Start_i pulse during the dump is ignored.
- Snapshot: write RF[3]=0xDEAD during SEND of word 3. The dumped word keeps its old value.
- Reset during SEND of the second word: all outputs go to 0 immediately and Done_o never pulses. A new Start_i after reset release dumps correctly.
